// File: rtl/tlul_to_reg.sv
// -----------------------------------------------------------------------------
// tlul_to_reg : TL-UL device-side adapter driving one register-interface
// initiator port. A single transaction is in flight at a time. The A-channel
// beat is checked for protocol errors, converted into a register request, and
// the register response is returned on the D channel.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   tl_i       TL-UL A channel and d_ready from the host
//   tl_o       TL-UL D channel and a_ready to the host
//   reg_req_o  register request (addr, write, wdata, wstrb, valid)
//   reg_rsp_i  register response (rdata, error, ready)
//
// Optional feature macro: TLUL_TO_REG_TIMEOUT_EN
//   When defined, a request that sees no ready for TimeoutCycles cycles is
//   aborted and answered with d_error = 1. When undefined, REQ waits forever.
// -----------------------------------------------------------------------------

package tlul_pkg;
  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

package core_v_mcu_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module tlul_to_reg #(
  parameter int unsigned TimeoutCycles = 32'd1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  tlul_pkg::tl_h2d_t        tl_i,
  output tlul_pkg::tl_d2h_t        tl_o,
  output core_v_mcu_pkg::reg_req_t reg_req_o,
  input  core_v_mcu_pkg::reg_rsp_t reg_rsp_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_e;

  // An access must be naturally aligned to its size; size 3 is never legal.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr_lsb[0];
      2'd2:    misaligned = |addr_lsb;
      default: misaligned = 1'b1;
    endcase
  endfunction

  state_e      state_r;
  logic [2:0]  op_r;
  logic [1:0]  size_r;
  logic [7:0]  source_r;

  logic        a_ready_r;
  logic        d_valid_r;
  logic [2:0]  d_opcode_r;
  logic [1:0]  d_size_r;
  logic [7:0]  d_source_r;
  logic [31:0] d_data_r;
  logic        d_error_r;

  logic        req_valid_r;
  logic [31:0] req_addr_r;
  logic        req_write_r;
  logic [31:0] req_wdata_r;
  logic [3:0]  req_wstrb_r;

  logic        a_is_get_s;
  logic        a_is_put_s;
  logic        a_err_s;
  logic        op_is_get_s;
  logic        tmo_expire_s;
  logic        unused_tl_s;

  // Protocol checks on the incoming A beat.
  always_comb begin
    a_is_get_s = (tl_i.a_opcode == tlul_pkg::GET);
    a_is_put_s = (tl_i.a_opcode == tlul_pkg::PUT_FULL_DATA) ||
                 (tl_i.a_opcode == tlul_pkg::PUT_PARTIAL_DATA);
    a_err_s    = 1'b0;
    if (!(a_is_get_s || a_is_put_s)) begin
      a_err_s = 1'b1;
    end else if (misaligned(tl_i.a_size, tl_i.a_address[1:0])) begin
      a_err_s = 1'b1;
    end else if (a_is_put_s && (tl_i.a_mask == 4'h0)) begin
      a_err_s = 1'b1;
    end else begin
      a_err_s = 1'b0;
    end
  end

  assign op_is_get_s = (op_r == tlul_pkg::GET);
  assign unused_tl_s = ^{tl_i.a_param, tl_i.a_user};

`ifdef TLUL_TO_REG_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;

  // Cycle counter for the current REQ phase; parked at zero outside REQ.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_r <= 32'd0;
    end else if (state_r != REQ) begin
      tmo_cnt_r <= 32'd0;
    end else if (!reg_rsp_i.ready) begin
      tmo_cnt_r <= tmo_cnt_r + 32'd1;
    end
  end

  // A ready arriving in the expiry cycle takes precedence over the abort.
  assign tmo_expire_s = (TimeoutCycles != 32'd0) && (state_r == REQ) &&
                        !reg_rsp_i.ready && (tmo_cnt_r == TimeoutCycles - 32'd1);
`else
  logic unused_tmo_s;
  assign tmo_expire_s = 1'b0;
  assign unused_tmo_s = ^TimeoutCycles;
`endif

  // Transaction FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      op_r        <= 3'd0;
      size_r      <= 2'd0;
      source_r    <= 8'd0;
      a_ready_r   <= 1'b1;
      d_valid_r   <= 1'b0;
      d_opcode_r  <= 3'd0;
      d_size_r    <= 2'd0;
      d_source_r  <= 8'd0;
      d_data_r    <= 32'd0;
      d_error_r   <= 1'b0;
      req_valid_r <= 1'b0;
      req_addr_r  <= 32'd0;
      req_write_r <= 1'b0;
      req_wdata_r <= 32'd0;
      req_wstrb_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (tl_i.a_valid) begin
            op_r      <= tl_i.a_opcode;
            size_r    <= tl_i.a_size;
            source_r  <= tl_i.a_source;
            a_ready_r <= 1'b0;
            if (a_err_s) begin
              // Rejected beat: answer immediately without touching the bus.
              state_r    <= RSP;
              d_valid_r  <= 1'b1;
              d_opcode_r <= a_is_get_s ? tlul_pkg::ACCESS_ACK_DATA : tlul_pkg::ACCESS_ACK;
              d_size_r   <= tl_i.a_size;
              d_source_r <= tl_i.a_source;
              d_data_r   <= a_is_get_s ? 32'hFFFF_FFFF : 32'd0;
              d_error_r  <= 1'b1;
            end else begin
              state_r     <= REQ;
              req_valid_r <= 1'b1;
              req_addr_r  <= {tl_i.a_address[31:2], 2'b00};
              req_write_r <= !a_is_get_s;
              req_wdata_r <= tl_i.a_data;
              req_wstrb_r <= a_is_get_s ? 4'd0 : tl_i.a_mask;
            end
          end
        end
        REQ: begin
          if (reg_rsp_i.ready || tmo_expire_s) begin
            state_r     <= RSP;
            req_valid_r <= 1'b0;
            req_addr_r  <= 32'd0;
            req_write_r <= 1'b0;
            req_wdata_r <= 32'd0;
            req_wstrb_r <= 4'd0;
            d_valid_r   <= 1'b1;
            d_opcode_r  <= op_is_get_s ? tlul_pkg::ACCESS_ACK_DATA : tlul_pkg::ACCESS_ACK;
            d_size_r    <= size_r;
            d_source_r  <= source_r;
            // A timeout only wins when ready is absent (tmo_expire_s implies !ready).
            if (tmo_expire_s || reg_rsp_i.error) begin
              d_error_r <= 1'b1;
              d_data_r  <= op_is_get_s ? 32'hFFFF_FFFF : 32'd0;
            end else begin
              d_error_r <= 1'b0;
              d_data_r  <= op_is_get_s ? reg_rsp_i.rdata : 32'd0;
            end
          end
        end
        RSP: begin
          if (tl_i.d_ready) begin
            state_r    <= IDLE;
            a_ready_r  <= 1'b1;
            d_valid_r  <= 1'b0;
            d_opcode_r <= 3'd0;
            d_size_r   <= 2'd0;
            d_source_r <= 8'd0;
            d_data_r   <= 32'd0;
            d_error_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          a_ready_r   <= 1'b1;
          d_valid_r   <= 1'b0;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign tl_o = '{
    d_valid:  d_valid_r,
    d_opcode: d_opcode_r,
    d_param:  3'd0,
    d_size:   d_size_r,
    d_source: d_source_r,
    d_sink:   1'b0,
    d_data:   d_data_r,
    d_user:   16'd0,
    d_error:  d_error_r,
    a_ready:  a_ready_r
  };

  assign reg_req_o = '{
    addr:  req_addr_r,
    write: req_write_r,
    wdata: req_wdata_r,
    wstrb: req_wstrb_r,
    valid: req_valid_r
  };

endmodule

// File: tb/tb_tlul_to_reg.sv
// -----------------------------------------------------------------------------
// tb_tlul_to_reg : directed self-checking bench for tlul_to_reg.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tlul_to_reg;

  logic                     clk;
  logic                     rst_n;
  tlul_pkg::tl_h2d_t        tl_h2d;
  tlul_pkg::tl_d2h_t        tl_d2h;
  core_v_mcu_pkg::reg_req_t reg_req;
  core_v_mcu_pkg::reg_rsp_t reg_rsp;

  int n_tests = 0;
  int n_fail  = 0;

  tlul_to_reg #(.TimeoutCycles(32'd8)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .tl_i      (tl_h2d),
    .tl_o      (tl_d2h),
    .reg_req_o (reg_req),
    .reg_rsp_i (reg_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                        input logic [7:0] src, input logic [3:0] mask, input logic [31:0] data);
    tl_h2d.a_valid   = 1'b1;
    tl_h2d.a_opcode  = op;
    tl_h2d.a_address = addr;
    tl_h2d.a_size    = size;
    tl_h2d.a_source  = src;
    tl_h2d.a_mask    = mask;
    tl_h2d.a_data    = data;
    tl_h2d.a_user    = 16'hA5A5;
  endtask

  // Rejected beat: D response one cycle after acceptance, no register access.
  task automatic err_case(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [1:0] size, input logic [3:0] mask,
                          input logic [2:0] exp_op, input logic [31:0] exp_data);
    send_a(op, addr, size, 8'd3, mask, 32'h0);
    tick();
    tl_h2d.a_valid = 1'b0;
    chk({tag, "_req_valid"}, 32'(reg_req.valid), 32'd0);
    chk({tag, "_d_valid"}, 32'(tl_d2h.d_valid), 32'd1);
    chk({tag, "_d_error"}, 32'(tl_d2h.d_error), 32'd1);
    chk({tag, "_d_opcode"}, 32'(tl_d2h.d_opcode), 32'(exp_op));
    chk({tag, "_d_data"}, tl_d2h.d_data, exp_data);
    tick();
    chk({tag, "_idle_a_ready"}, 32'(tl_d2h.a_ready), 32'd1);
    chk({tag, "_no_access"}, 32'(reg_req.valid), 32'd0);
  endtask

  initial begin
    tl_h2d = '0;
    tl_h2d.d_ready = 1'b1;
    reg_rsp = '0;
    rst_n = 1'b0;

    // Reset state
    #12;
    chk("rst_a_ready", 32'(tl_d2h.a_ready), 32'd1);
    chk("rst_d_valid", 32'(tl_d2h.d_valid), 32'd0);
    chk("rst_d_data", tl_d2h.d_data, 32'd0);
    chk("rst_req_valid", 32'(reg_req.valid), 32'd0);
    chk("rst_req_addr", reg_req.addr, 32'd0);
    #8 rst_n = 1'b1;
    tick();

    // Get 0x40, zero-wait slave: 3-cycle round trip
    chk("get_a_ready", 32'(tl_d2h.a_ready), 32'd1);
    send_a(tlul_pkg::GET, 32'h40, 2'd2, 8'd5, 4'hF, 32'h0);
    reg_rsp.ready = 1'b1;
    reg_rsp.rdata = 32'hCAFE_F00D;
    tick();
    tl_h2d.a_valid = 1'b0;
    chk("get_req_valid", 32'(reg_req.valid), 32'd1);
    chk("get_req_addr", reg_req.addr, 32'h40);
    chk("get_req_write", 32'(reg_req.write), 32'd0);
    chk("get_req_wstrb", 32'(reg_req.wstrb), 32'd0);
    chk("get_a_ready_busy", 32'(tl_d2h.a_ready), 32'd0);
    tick();
    chk("get_d_valid", 32'(tl_d2h.d_valid), 32'd1);
    chk("get_d_opcode", 32'(tl_d2h.d_opcode), 32'd1);
    chk("get_d_data", tl_d2h.d_data, 32'hCAFE_F00D);
    chk("get_d_source", 32'(tl_d2h.d_source), 32'd5);
    chk("get_d_size", 32'(tl_d2h.d_size), 32'd2);
    chk("get_d_error", 32'(tl_d2h.d_error), 32'd0);
    chk("get_d_user", 32'(tl_d2h.d_user), 32'd0);
    chk("get_req_dropped", 32'(reg_req.valid), 32'd0);
    tick();
    chk("get_back_idle", 32'(tl_d2h.a_ready), 32'd1);
    chk("get_d_done", 32'(tl_d2h.d_valid), 32'd0);

    // PutPartialData 0x44, slave delays ready: valid held 5 cycles
    reg_rsp.ready = 1'b0;
    send_a(tlul_pkg::PUT_PARTIAL_DATA, 32'h44, 2'd2, 8'd7, 4'b0011, 32'h1234_5678);
    tick();
    tl_h2d.a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("put_req_valid", 32'(reg_req.valid), 32'd1);
      chk("put_req_write", 32'(reg_req.write), 32'd1);
      chk("put_req_addr", reg_req.addr, 32'h44);
      chk("put_req_wstrb", 32'(reg_req.wstrb), 32'h3);
      chk("put_req_wdata", reg_req.wdata, 32'h1234_5678);
      chk("put_no_d", 32'(tl_d2h.d_valid), 32'd0);
      if (i == 4) reg_rsp.ready = 1'b1;
      tick();
    end
    reg_rsp.ready = 1'b0;
    chk("put_d_valid", 32'(tl_d2h.d_valid), 32'd1);
    chk("put_d_opcode", 32'(tl_d2h.d_opcode), 32'd0);
    chk("put_d_error", 32'(tl_d2h.d_error), 32'd0);
    chk("put_d_data", tl_d2h.d_data, 32'd0);
    chk("put_d_source", 32'(tl_d2h.d_source), 32'd7);
    tick();

    // Protocol errors: misaligned Get, bad opcode, size 3, empty-mask Put
    err_case("misaligned", tlul_pkg::GET, 32'h42, 2'd2, 4'hF, 3'd1, 32'hFFFF_FFFF);
    err_case("bad_opcode", 3'd3, 32'h48, 2'd2, 4'hF, 3'd0, 32'd0);
    err_case("size3", tlul_pkg::GET, 32'h48, 2'd3, 4'hF, 3'd1, 32'hFFFF_FFFF);
    err_case("mask0", tlul_pkg::PUT_FULL_DATA, 32'h48, 2'd2, 4'h0, 3'd0, 32'd0);

    // Slave error on a write, with d_ready held low for 6 cycles
    reg_rsp.ready = 1'b1;
    reg_rsp.error = 1'b1;
    tl_h2d.d_ready = 1'b0;
    send_a(tlul_pkg::PUT_FULL_DATA, 32'h50, 2'd2, 8'd9, 4'hF, 32'hAABB_CCDD);
    tick();
    send_a(tlul_pkg::GET, 32'h60, 2'd2, 8'd1, 4'hF, 32'h0);
    chk("werr_req_wstrb", 32'(reg_req.wstrb), 32'hF);
    chk("werr_req_wdata", reg_req.wdata, 32'hAABB_CCDD);
    tick();
    reg_rsp.error = 1'b0;
    reg_rsp.ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("stall_d_valid", 32'(tl_d2h.d_valid), 32'd1);
      chk("stall_d_error", 32'(tl_d2h.d_error), 32'd1);
      chk("stall_d_opcode", 32'(tl_d2h.d_opcode), 32'd0);
      chk("stall_d_source", 32'(tl_d2h.d_source), 32'd9);
      chk("stall_a_ready", 32'(tl_d2h.a_ready), 32'd0);
      chk("stall_no_req", 32'(reg_req.valid), 32'd0);
      tick();
    end
    tl_h2d.a_valid = 1'b0;
    tl_h2d.d_ready = 1'b1;
    chk("stall_still_d", 32'(tl_d2h.d_valid), 32'd1);
    tick();
    chk("stall_released", 32'(tl_d2h.a_ready), 32'd1);
    tick();
    chk("stall_no_extra_req", 32'(reg_req.valid), 32'd0);

    // Slave never ready
    send_a(tlul_pkg::GET, 32'h70, 2'd2, 8'd2, 4'hF, 32'h0);
    tick();
    tl_h2d.a_valid = 1'b0;
`ifdef TLUL_TO_REG_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("tmo_valid_window", 32'(reg_req.valid), 32'd1);
      tick();
    end
    chk("tmo_valid_drop", 32'(reg_req.valid), 32'd0);
    chk("tmo_d_valid", 32'(tl_d2h.d_valid), 32'd1);
    chk("tmo_d_error", 32'(tl_d2h.d_error), 32'd1);
    chk("tmo_d_data", tl_d2h.d_data, 32'hFFFF_FFFF);
    tick();
`else
    for (int i = 0; i < 100; i++) tick();
    chk("notmo_valid_held", 32'(reg_req.valid), 32'd1);
    chk("notmo_no_d", 32'(tl_d2h.d_valid), 32'd0);
    reg_rsp.ready = 1'b1;
    reg_rsp.rdata = 32'h0BAD_CAFE;
    tick();
    reg_rsp.ready = 1'b0;
    chk("notmo_d_data", tl_d2h.d_data, 32'h0BAD_CAFE);
    chk("notmo_d_error", 32'(tl_d2h.d_error), 32'd0);
    tick();
`endif
    chk("tmo_back_idle", 32'(tl_d2h.a_ready), 32'd1);

    // Reset during REQ, then a normal Get
    send_a(tlul_pkg::GET, 32'h80, 2'd2, 8'd4, 4'hF, 32'h0);
    tick();
    tl_h2d.a_valid = 1'b0;
    chk("mid_req_valid", 32'(reg_req.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(reg_req.valid), 32'd0);
    chk("async_rst_d_valid", 32'(tl_d2h.d_valid), 32'd0);
    chk("async_rst_a_ready", 32'(tl_d2h.a_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_a_ready", 32'(tl_d2h.a_ready), 32'd1);
    chk("post_rst_no_req", 32'(reg_req.valid), 32'd0);
    send_a(tlul_pkg::GET, 32'h84, 2'd2, 8'd6, 4'hF, 32'h0);
    reg_rsp.ready = 1'b1;
    reg_rsp.rdata = 32'h55AA_33CC;
    tick();
    tl_h2d.a_valid = 1'b0;
    chk("post_rst_req_addr", reg_req.addr, 32'h84);
    tick();
    chk("post_rst_d_data", tl_d2h.d_data, 32'h55AA_33CC);
    chk("post_rst_d_source", 32'(tl_d2h.d_source), 32'd6);
    tick();
    chk("post_rst_idle", 32'(tl_d2h.a_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
